// File: rtl/arq_pkg.sv
// ----------------------------------------------------------------------------
// arq_pkg
// Shared definitions for the ARQ receiver (and its matching transmitter):
//   - arq_state_t : receiver FSM states
//   - CHK_KEY     : constant folded into every frame checksum
//   - ACK / NAK   : encodings driven on the response ack_nak line
//   - arq_checksum: frame checksum, data ^ zero-extended seq ^ CHK_KEY
// ----------------------------------------------------------------------------
package arq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } arq_state_t;

   localparam logic [7:0] CHK_KEY = 8'hA5;
   localparam logic       ACK     = 1'b0;
   localparam logic       NAK     = 1'b1;

   // Caller zero-extends the sequence number to 8 bits before calling.
   function automatic logic [7:0] arq_checksum(input logic [7:0] data,
                                               input logic [7:0] seq_ext);
      return data ^ seq_ext ^ CHK_KEY;
   endfunction

endpackage

// File: rtl/arq_rx_fifo.sv
// ----------------------------------------------------------------------------
// arq_rx_fifo
// First-word-fall-through payload FIFO for the ARQ receiver.
// Pointers carry one extra wrap bit so full and empty are told apart by the
// MSB. Push while full and pop while empty are ignored.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_push/i_data : write request and byte
//   i_pop         : read request (acts only when o_valid)
//   o_valid       : FIFO non-empty
//   o_data        : head entry, forced to zero while empty
//   o_count       : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module arq_rx_fifo
   import arq_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic                       o_valid,
   output logic [WIDTH-1:0]           o_data,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int             AW      = $clog2(DEPTH);
   localparam logic [AW:0]    PTR_ONE = (AW+1)'(1'b1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_empty;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = i_push && !w_full;
   assign w_do_pop  = i_pop && !w_empty;

   assign o_valid = !w_empty;
   assign o_data  = w_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr[AW-1:0]];
   assign o_count = r_wr_ptr - r_rd_ptr;

   // Read/write pointer update; reset empties the FIFO.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= {(AW+1){1'b0}};
         r_rd_ptr <= {(AW+1){1'b0}};
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage array; no write lands on a reset edge.
   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_rst) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

endmodule

// File: rtl/arq_rx_fsm.sv
// ----------------------------------------------------------------------------
// arq_rx_fsm
// Receive-side ARQ engine. Accepts one sequence-numbered, checksummed frame
// at a time, judges it, pushes in-order payload into a FWFT FIFO and returns
// exactly one ACK or NAK per frame. Throughput is one frame per three cycles
// (IDLE accept -> CHECK decide -> RESP handshake).
// Ports:
//   i_clk, i_rst                     : clock, synchronous active-high reset
//   i_rx_valid/o_rx_ready            : frame handshake
//   i_rx_seq/i_rx_data/i_rx_chk      : frame fields
//   o_ack_valid/i_ack_ready          : response handshake
//   o_ack_nak/o_ack_seq              : response kind and sequence number
//   o_out_valid/i_out_ready/o_out_data : payload FIFO consumer side
//   o_exp_seq                        : next expected sequence number
//   o_err_cnt                        : saturating count of NAKs issued
// ----------------------------------------------------------------------------
module arq_rx_fsm
   import arq_pkg::*;
#(
   parameter int SEQ_W = 3,
   parameter int DEPTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_rx_valid,
   output logic             o_rx_ready,
   input  logic [SEQ_W-1:0] i_rx_seq,
   input  logic [7:0]       i_rx_data,
   input  logic [7:0]       i_rx_chk,
   output logic             o_ack_valid,
   input  logic             i_ack_ready,
   output logic             o_ack_nak,
   output logic [SEQ_W-1:0] o_ack_seq,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [7:0]       o_out_data,
   output logic [SEQ_W-1:0] o_exp_seq,
   output logic [7:0]       o_err_cnt
);

   localparam int               AW        = $clog2(DEPTH);
   localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1'b1);
   localparam logic [AW:0]      CNT_DEPTH = DEPTH[AW:0];

   arq_state_t       r_state;
   arq_state_t       w_next_state;

   logic             r_rx_ready;
   logic             r_ack_valid;
   logic             r_ack_nak;
   logic [SEQ_W-1:0] r_ack_seq;
   logic [SEQ_W-1:0] r_seq;
   logic [7:0]       r_data;
   logic [7:0]       r_chk;
   logic [SEQ_W-1:0] r_exp_seq;
   logic [7:0]       r_err_cnt;

   logic             w_chk_ok;
   logic [SEQ_W-1:0] w_exp_prev;
   logic [AW:0]      w_fifo_count;
   logic             w_fifo_full;
   logic             w_fifo_push;
   logic             w_dec_nak;
   logic [SEQ_W-1:0] w_dec_seq;
   logic             w_dec_push;
   logic             w_dec_adv;

   assign w_chk_ok    = (r_chk == arq_checksum(r_data, 8'(r_seq)));
   assign w_exp_prev  = r_exp_seq - SEQ_ONE;
   // Fullness from the registered count: a same-cycle pop does not make room.
   assign w_fifo_full = (w_fifo_count == CNT_DEPTH);

   assign o_rx_ready  = r_rx_ready;
   assign o_ack_valid = r_ack_valid;
   assign o_ack_nak   = r_ack_nak;
   assign o_ack_seq   = r_ack_seq;
   assign o_exp_seq   = r_exp_seq;
   assign o_err_cnt   = r_err_cnt;

   arq_rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_fifo_push),
      .i_data  (r_data),
      .i_pop   (i_out_ready),
      .o_valid (o_out_valid),
      .o_data  (o_out_data),
      .o_count (w_fifo_count)
   );

   // Frame verdict on the latched frame, in priority order.
   always_comb begin
      w_dec_nak  = NAK;
      w_dec_seq  = r_exp_seq;
      w_dec_push = 1'b0;
      w_dec_adv  = 1'b0;
      if (!w_chk_ok) begin
         w_dec_nak = NAK;
         w_dec_seq = r_exp_seq;
      end else if (r_seq == r_exp_seq) begin
         if (!w_fifo_full) begin
            w_dec_nak  = ACK;
            w_dec_seq  = r_seq;
            w_dec_push = 1'b1;
            w_dec_adv  = 1'b1;
         end else begin
            w_dec_nak = NAK;
            w_dec_seq = r_exp_seq;
         end
      end else if (r_seq == w_exp_prev) begin
         // Duplicate of the last accepted frame: its ACK was probably lost.
         w_dec_nak = ACK;
         w_dec_seq = r_seq;
      end else begin
         w_dec_nak = NAK;
         w_dec_seq = r_exp_seq;
      end
   end

   // Next-state logic and the FIFO write strobe.
   always_comb begin
      w_next_state = r_state;
      w_fifo_push  = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_rx_valid && r_rx_ready) begin
               w_next_state = CHECK;
            end else begin
               w_next_state = IDLE;
            end
         end
         CHECK: begin
            w_next_state = RESP;
            w_fifo_push  = w_dec_push;
         end
         RESP: begin
            if (r_ack_valid && i_ack_ready) begin
               w_next_state = IDLE;
            end else begin
               w_next_state = RESP;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Registered handshakes, frame latch, response, sequence and error counter.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_ready  <= 1'b1;
         r_ack_valid <= 1'b0;
         r_ack_nak   <= ACK;
         r_ack_seq   <= {SEQ_W{1'b0}};
         r_seq       <= {SEQ_W{1'b0}};
         r_data      <= 8'h00;
         r_chk       <= 8'h00;
         r_exp_seq   <= {SEQ_W{1'b0}};
         r_err_cnt   <= 8'h00;
      end else begin
         // Handshake flags follow the next state so they are glitch-free flops.
         r_rx_ready  <= (w_next_state == IDLE);
         r_ack_valid <= (w_next_state == RESP);
         if ((r_state == IDLE) && i_rx_valid && r_rx_ready) begin
            r_seq  <= i_rx_seq;
            r_data <= i_rx_data;
            r_chk  <= i_rx_chk;
         end
         if (r_state == CHECK) begin
            r_ack_nak <= w_dec_nak;
            r_ack_seq <= w_dec_seq;
            if (w_dec_adv) begin
               r_exp_seq <= r_exp_seq + SEQ_ONE;
            end
            if ((w_dec_nak == NAK) && (r_err_cnt != 8'hFF)) begin
               r_err_cnt <= r_err_cnt + 8'h01;
            end
         end
      end
   end

endmodule

// File: tb/tb_arq_rx_fsm.sv
module tb_arq_rx_fsm;

   localparam int SEQ_W = 3;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             rx_valid;
   logic             rx_ready;
   logic [SEQ_W-1:0] rx_seq;
   logic [7:0]       rx_data;
   logic [7:0]       rx_chk;
   logic             ack_valid;
   logic             ack_ready;
   logic             ack_nak;
   logic [SEQ_W-1:0] ack_seq;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [SEQ_W-1:0] exp_seq;
   logic [7:0]       err_cnt;

   always #5 clk = ~clk;

   arq_rx_fsm #(.SEQ_W(SEQ_W), .DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx_valid  (rx_valid),
      .o_rx_ready  (rx_ready),
      .i_rx_seq    (rx_seq),
      .i_rx_data   (rx_data),
      .i_rx_chk    (rx_chk),
      .o_ack_valid (ack_valid),
      .i_ack_ready (ack_ready),
      .o_ack_nak   (ack_nak),
      .o_ack_seq   (ack_seq),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_exp_seq   (exp_seq),
      .o_err_cnt   (err_cnt)
   );

   typedef struct packed {
      logic             nak;
      logic [SEQ_W-1:0] seq;
   } ack_t;

   ack_t       ack_q[$];
   logic [7:0] data_q[$];
   logic [2:0] m_exp;
   logic [7:0] m_err;
   int         n_pass  = 0;
   int         n_total = 0;

   function automatic logic [7:0] good_chk(input logic [2:0] s, input logic [7:0] d);
      return d ^ {5'b00000, s} ^ 8'hA5;
   endfunction

   // Reference receiver: predicts the response and any FIFO push.
   task automatic model_frame(input logic [2:0] s, input logic [7:0] d, input logic [7:0] c);
      ack_t a;
      if (c != good_chk(s, d)) begin
         a.nak = 1'b1; a.seq = m_exp;
      end else if (s == m_exp) begin
         if (data_q.size() < DEPTH) begin
            a.nak = 1'b0; a.seq = s;
            data_q.push_back(d);
            m_exp = m_exp + 3'd1;
         end else begin
            a.nak = 1'b1; a.seq = m_exp;
         end
      end else if (s == 3'(m_exp - 3'd1)) begin
         a.nak = 1'b0; a.seq = s;
      end else begin
         a.nak = 1'b1; a.seq = m_exp;
      end
      if (a.nak && (m_err != 8'hFF)) m_err = m_err + 8'd1;
      ack_q.push_back(a);
   endtask

   task automatic send_frame(input logic [2:0] s, input logic [7:0] d, input logic [7:0] c,
                             input int stall);
      ack_t e;
      model_frame(s, d, c);
      rx_seq = s; rx_data = d; rx_chk = c; rx_valid = 1'b1;
      n_total++; if (rx_ready !== 1'b1) $display("FAIL rx_ready_idle: got %0h want 1", rx_ready); else n_pass++;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      n_total++; if (ack_valid !== 1'b0) $display("FAIL ack_valid_check: got %0h want 0", ack_valid); else n_pass++;
      n_total++; if (rx_ready !== 1'b0) $display("FAIL rx_ready_check: got %0h want 0", rx_ready); else n_pass++;
      @(posedge clk); #1;
      e = ack_q.pop_front();
      n_total++; if (ack_valid !== 1'b1) $display("FAIL ack_valid_resp: got %0h want 1", ack_valid); else n_pass++;
      n_total++; if (ack_nak !== e.nak) $display("FAIL ack_nak seq%0d: got %0h want %0h", s, ack_nak, e.nak); else n_pass++;
      n_total++; if (ack_seq !== e.seq) $display("FAIL ack_seq seq%0d: got %0d want %0d", s, ack_seq, e.seq); else n_pass++;
      n_total++; if (exp_seq !== m_exp) $display("FAIL exp_seq: got %0d want %0d", exp_seq, m_exp); else n_pass++;
      n_total++; if (err_cnt !== m_err) $display("FAIL err_cnt: got %0d want %0d", err_cnt, m_err); else n_pass++;
      n_total++; if (out_valid !== (data_q.size() != 0)) $display("FAIL out_valid: got %0h want %0h", out_valid, data_q.size() != 0); else n_pass++;
      if (data_q.size() != 0) begin
         n_total++; if (out_data !== data_q[0]) $display("FAIL out_data_head: got %02h want %02h", out_data, data_q[0]); else n_pass++;
      end
      if (stall > 0) begin
         ack_ready = 1'b0;
         for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            n_total++; if (ack_valid !== 1'b1) $display("FAIL stall_ack_valid: got %0h want 1", ack_valid); else n_pass++;
            n_total++; if ({ack_nak, ack_seq} !== e) $display("FAIL stall_ack_hold: got %0h want %0h", {ack_nak, ack_seq}, e); else n_pass++;
            n_total++; if (rx_ready !== 1'b0) $display("FAIL stall_rx_ready: got %0h want 0", rx_ready); else n_pass++;
         end
         ack_ready = 1'b1;
      end
      @(posedge clk); #1;
      n_total++; if (ack_valid !== 1'b0) $display("FAIL ack_valid_after_hs: got %0h want 0", ack_valid); else n_pass++;
      n_total++; if (rx_ready !== 1'b1) $display("FAIL rx_ready_after_hs: got %0h want 1", rx_ready); else n_pass++;
   endtask

   task automatic pop_bytes(input int n);
      logic [7:0] d;
      for (int k = 0; k < n; k++) begin
         if (data_q.size() == 0) begin
            n_total++; if (out_valid !== 1'b0) $display("FAIL out_valid_empty: got %0h want 0", out_valid); else n_pass++;
         end else begin
            d = data_q.pop_front();
            n_total++; if (out_valid !== 1'b1) $display("FAIL out_valid_pop: got %0h want 1", out_valid); else n_pass++;
            n_total++; if (out_data !== d) $display("FAIL out_data_pop: got %02h want %02h", out_data, d); else n_pass++;
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic check_after_reset(input string tag);
      n_total++; if (ack_valid !== 1'b0) $display("FAIL %s ack_valid: got %0h want 0", tag, ack_valid); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL %s out_valid: got %0h want 0", tag, out_valid); else n_pass++;
      n_total++; if (exp_seq !== 3'd0) $display("FAIL %s exp_seq: got %0d want 0", tag, exp_seq); else n_pass++;
      n_total++; if (err_cnt !== 8'd0) $display("FAIL %s err_cnt: got %0d want 0", tag, err_cnt); else n_pass++;
      n_total++; if (rx_ready !== 1'b1) $display("FAIL %s rx_ready: got %0h want 1", tag, rx_ready); else n_pass++;
   endtask

   task automatic model_reset();
      ack_q.delete();
      data_q.delete();
      m_exp = 3'd0;
      m_err = 8'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_after_reset("reset");
      n_total++; if (ack_nak !== 1'b0) $display("FAIL reset ack_nak: got %0h want 0", ack_nak); else n_pass++;
      n_total++; if (ack_seq !== 3'd0) $display("FAIL reset ack_seq: got %0d want 0", ack_seq); else n_pass++;
      n_total++; if (out_data !== 8'h00) $display("FAIL reset out_data: got %02h want 00", out_data); else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_in_order();
      send_frame(3'd0, 8'h3C, 8'h99, 0);
   endtask

   task automatic test_bad_chk();
      send_frame(3'd1, 8'h5A, 8'h00, 0);
      send_frame(3'd1, 8'h5A, 8'hFE, 0);
   endtask

   task automatic test_dup_ooo();
      send_frame(3'd1, 8'h5A, 8'hFE, 0);
      send_frame(3'd5, 8'h00, 8'hA0, 0);
   endtask

   task automatic test_fifo_full();
      logic [2:0] s;
      logic [7:0] d;
      pop_bytes(data_q.size());
      for (int k = 0; k < DEPTH; k++) begin
         s = m_exp;
         d = 8'($urandom);
         send_frame(s, d, good_chk(s, d), 0);
      end
      s = m_exp;
      d = 8'hC3;
      send_frame(s, d, good_chk(s, d), 0);   // full: NAK, exp_seq held
      pop_bytes(1);
      send_frame(s, d, good_chk(s, d), 0);   // room again: ACK
      pop_bytes(DEPTH + 1);                  // drains exactly DEPTH, then empty
   endtask

   task automatic test_wrap_backpressure();
      logic [2:0] s;
      logic [7:0] d;
      for (int k = 0; k < 9; k++) begin
         s = m_exp;
         d = 8'(k * 17 + 3);
         send_frame(s, d, good_chk(s, d), (k == 2) ? 5 : 0);
         pop_bytes(1);
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] s;
      s = m_exp;
      send_frame(s, 8'h11, good_chk(s, 8'h11), 0);
      // Reset on the CHECK decision edge.
      s = m_exp;
      rx_seq = s; rx_data = 8'h22; rx_chk = good_chk(s, 8'h22); rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      check_after_reset("rst_check");
      // Reset while the response is stalled.
      rx_seq = 3'd0; rx_data = 8'h44; rx_chk = good_chk(3'd0, 8'h44); rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0; ack_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; ack_ready = 1'b1;
      check_after_reset("rst_resp");
      send_frame(3'd0, 8'h3C, 8'h99, 0);
      pop_bytes(2);
   endtask

   initial begin
      rx_valid = 1'b0; rx_seq = 3'd0; rx_data = 8'h00; rx_chk = 8'h00;
      ack_ready = 1'b1; out_ready = 1'b0; rst = 1'b1;
      m_exp = 3'd0; m_err = 8'd0;
      test_reset();
      test_in_order();
      test_bad_chk();
      test_dup_ooo();
      test_fifo_full();
      test_wrap_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/arq_rx_fsm.md
Name: arq_rx_fsm

Overview:
Receive-side ARQ engine pairing with the tt_um_tx_fsm transmitter. It accepts sequence-numbered, checksummed frames and validates checksum and sequence order. In-order payload bytes are pushed into a local FIFO for the consumer, and every frame gets exactly one ACK or NAK response back to the transmitter. It sits between the link input and the user data sink, closing the stop-and-wait / go-back loop.

Parameters:
SEQ_W, 3, sequence number width; sequence space is 2^SEQ_W and wraps modulo that.
DEPTH, 8, payload FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
rx_valid  input  1  frame present on rx_seq/rx_data/rx_chk
rx_ready  output  1  receiver can accept a frame
rx_seq  input  SEQ_W  frame sequence number
rx_data  input  8  frame payload byte
rx_chk  input  8  frame checksum
ack_valid  output  1  response pending
ack_ready  input  1  transmitter takes response
ack_nak  output  1  0 = ACK, 1 = NAK
ack_seq  output  SEQ_W  ACK: seq of frame acknowledged; NAK: expected seq
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer pops
out_data  output  8  FIFO head byte
exp_seq  output  SEQ_W  next expected sequence number
err_cnt  output  8  saturating count of NAKs issued

Behaviour:
- Reset values (rst=1 at clock edge):
  - state = IDLE, rx_ready = 1, ack_valid = 0, ack_nak = 0, ack_seq = 0.
  - FIFO emptied, so out_valid = 0; out_data = 0.
  - exp_seq = 0, err_cnt = 0.
  - Reset mid-frame or mid-response discards the latched frame and any pending ACK. No FIFO write occurs on the reset edge.
- Checksum: good iff rx_chk == rx_data ^ zero_ext(rx_seq) ^ 8'hA5.
- FSM states: IDLE, CHECK, RESP.
  - IDLE: rx_ready = 1. On rx_valid & rx_ready, latch seq/data/chk and go to CHECK.
  - CHECK: rx_ready = 0. The decision is made on this cycle's edge; go to RESP with ack_* registered. Priority of decisions:
    1. Bad checksum: NAK, ack_seq = exp_seq, no write.
    2. seq == exp_seq and FIFO count < DEPTH: push data, ACK with ack_seq = seq, exp_seq increments (wraps 2^SEQ_W-1 to 0).
    3. seq == exp_seq and FIFO full: NAK with ack_seq = exp_seq (flow-control drop). Fullness uses the count before any same-cycle pop; there is no pop bypass.
    4. seq == exp_seq-1 (mod 2^SEQ_W), i.e. a duplicate: ACK with ack_seq = seq, no write, exp_seq unchanged.
    5. Any other seq: NAK with ack_seq = exp_seq.
  - RESP: ack_valid = 1, and ack_nak/ack_seq are held stable until ack_ready. On ack_valid & ack_ready, go to IDLE. If ack_ready is already high on entry, ack_valid is high for exactly one cycle.
- Latency:
  - Frame accepted at edge N; FIFO write at edge N+1; ack_valid high from cycle N+1 (after edge N+1).
  - Earliest next accept is the edge after ack handshake, giving a throughput of 1 frame per 3 cycles.
- err_cnt increments by 1 for every NAK at the CHECK edge and saturates at 255.
- FIFO:
  - First-word fall-through: out_data is valid whenever out_valid = 1.
  - A pop happens on out_valid & out_ready. A pop on empty is ignored.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers are log2(DEPTH)+1 bits wide, with full/empty distinguished by the MSB.
- The consumer side (out_*) runs independently of the FSM state.

Decomposition:
- Package arq_pkg holds:
  - state enum {IDLE, CHECK, RESP};
  - CHK_KEY = 8'hA5;
  - ACK = 1'b0 and NAK = 1'b1 encodings;
  - a checksum function shared with the transmitter.
- One sub-module, arq_rx_fifo (DEPTH, 8-bit, FWFT, synchronous active-high reset, count output). The FSM, sequence logic and counters stay in arq_rx_fsm.

Test Plan:
- In-order frame: after reset, send seq=0, data=0x3C, chk=0x99, with ack_ready held 1.
  - Required: ACK with ack_seq=0 at cycle N+1, out_data=0x3C with out_valid=1, exp_seq=1, err_cnt=0.
- Bad checksum: send seq=1, data=0x5A, chk=0x00.
  - Required: NAK with ack_seq=1, FIFO unchanged, err_cnt=1.
  - Resend with chk=0xFE. Required: ACK with ack_seq=1, exp_seq=2.
- Duplicate and out-of-order: with exp_seq=2, resend seq=1 (chk=0xFE).
  - Required: ACK with ack_seq=1, no FIFO push.
  - Then send seq=5, data=0x00, chk=0xA0. Required: NAK with ack_seq=2.
- FIFO full: with out_ready=0, send 8 good in-order frames, then a 9th with the correct seq.
  - Required: the 9th gets NAK with ack_seq equal to its seq, count stays 8, and exp_seq has not advanced past the 9th frame's seq.
  - Pop one byte, resend the 9th. Required: ACK.
- Wrap and backpressure: drive frames with seq 0..7 then 0 again; hold ack_ready=0 for 5 cycles on one of them.
  - Required: exp_seq wraps 7 to 0.
  - Required: ack_valid/ack_nak/ack_seq are stable while stalled, and rx_ready=0 until the handshake completes.
- Reset mid-operation: assert rst during CHECK and during RESP.
  - Required: next cycle ack_valid=0, out_valid=0, exp_seq=0, err_cnt=0, rx_ready=1, and no FIFO write occurred.
